mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified instruction/data RAM between the IF stage (fetch) and
//  the MEM stage (lw/sw). Grants one access at a time and sequences the fixed-latency read.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_lat_counter.sv | 35 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM single-port RAM arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Read-latency down-counter: loaded at read issue, flags the cycle ram_rdata is valid.
module arb_lat_counter #(
    parameter int MEM_LAT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Only loaded from idle, so the saturating decrement never has to wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(MEM_LAT - 1);
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port RAM between fetch (IF) and load/store (MEM),
// sequencing fixed-latency reads and returning registered data with a 1-cycle ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata
);
    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic              squash_q, squash_d;
    logic              if_ack_q, if_ack_d;
    logic              mem_ack_q, mem_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic mem_req, mem_cand, if_cand;
    logic issue_en, issue_we, cnt_load, cnt_dec, cnt_zero;

    assign mem_req = mem_rd_req | mem_wr_req;
    // A side acked this cycle is masked so its still-high request is not reissued.
    assign mem_cand = mem_req & ~mem_ack_q;
    assign if_cand  = if_req & ~if_ack_q & ~flush;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        squash_d    = squash_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        issue_en    = 1'b0;
        issue_we    = 1'b0;
        ram_addr    = if_addr;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                squash_d = 1'b0;
                if (mem_cand) begin
                    issue_en = 1'b1;
                    ram_addr = mem_addr;
                    if (mem_wr_req) begin
                        issue_we  = 1'b1;
                        mem_ack_d = 1'b1;
                    end else begin
                        owner_d  = OWN_MEM;
                        cnt_load = 1'b1;
                        state_d  = ARB_RD_WAIT;
                    end
                end else if (if_cand) begin
                    issue_en = 1'b1;
                    owner_d  = OWN_IF;
                    cnt_load = 1'b1;
                    state_d  = ARB_RD_WAIT;
                end
            end
            ARB_RD_WAIT: begin
                cnt_dec = 1'b1;
                if (owner_q == OWN_IF && flush) begin
                    squash_d = 1'b1;
                end
                if (cnt_zero) begin
                    state_d  = ARB_IDLE;
                    squash_d = 1'b0;
                    if (owner_q == OWN_MEM) begin
                        mem_rdata_d = ram_rdata;
                        mem_ack_d   = 1'b1;
                    end else if (!(squash_q || flush)) begin
                        if_rdata_d = ram_rdata;
                        if_ack_d   = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            squash_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            squash_q    <= squash_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat_cnt (
        .clock (clock),
        .reset (reset),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    // Strobes are gated by reset so nothing reaches the RAM while it is held low.
    assign ram_en    = issue_en & reset;
    assign ram_we    = issue_we & reset;
    assign ram_wdata = mem_wdata;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: DUT A (MEM_LAT=2) directed scenarios, DUT B (MEM_LAT=1) alternating stream.
module tb_mem_port_arbiter;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   nchk  = 0;
    int   nerr  = 0;

    exp_t q_if[$], q_mem[$], bq_if[$], bq_mem[$];

    logic        if_req, flush, mem_rd_req, mem_wr_req;
    logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
    logic        if_ack, mem_ack, stall_if, stall_mem, ram_en, ram_we;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;

    logic        b_if_req, b_flush, b_mem_rd_req, b_mem_wr_req;
    logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata, b_ram_rdata;
    logic        b_if_ack, b_mem_ack, b_stall_if, b_stall_mem, b_ram_en, b_ram_we;
    logic [31:0] b_if_rdata, b_mem_rdata, b_ram_addr, b_ram_wdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .flush(flush),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .ram_rdata(ram_rdata), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_b (
        .clock(clock), .reset(reset), .if_req(b_if_req), .if_addr(b_if_addr), .flush(b_flush),
        .mem_rd_req(b_mem_rd_req), .mem_wr_req(b_mem_wr_req), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .ram_rdata(b_ram_rdata), .if_ack(b_if_ack),
        .if_rdata(b_if_rdata), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem), .ram_en(b_ram_en), .ram_we(b_ram_we),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM model A: 2-cycle read pipe, junk between valid words.
    logic [31:0] amem [0:255];
    logic [31:0] apipe0, apipe1, bpipe;
    initial begin
        for (int i = 0; i < 256; i++) amem[i] = 32'h0;
        amem[8'h10] = 32'h2008_0005;
        amem[8'h11] = 32'h8C0A_0004;
        amem[8'h12] = 32'h0123_4567;
        amem[8'h13] = 32'hAC0B_0008;
        amem[8'h20] = 32'h0800_0080;
        amem[8'h40] = 32'h1111_0100;
    end
    always @(posedge clock) begin
        if (ram_en && ram_we) amem[ram_addr[9:2]] <= ram_wdata;
        apipe0 <= (ram_en && !ram_we) ? amem[ram_addr[9:2]] : 32'hBAD0_0BAD;
        apipe1 <= apipe0;
        bpipe  <= (b_ram_en && !b_ram_we) ? (b_ram_addr ^ 32'hA5A5_0000) : 32'hBAD0_0BAD;
    end
    assign ram_rdata   = apipe1;
    assign b_ram_rdata = bpipe;

    always @(negedge clock)
        assert (!(mem_rd_req && mem_wr_req)) else $error("illegal rd+wr request");

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Monitors: every ack pops the oldest expectation for that side.
    always @(negedge clock) begin
        exp_t e;
        if (if_ack) begin
            if (q_if.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL a_if_ack: unexpected ack at cycle %0d", cyc);
            end else begin
                e = q_if.pop_front();
                chk("a_if_rdata", if_rdata, e.data);
                chk("a_if_ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (mem_ack) begin
            if (q_mem.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL a_mem_ack: unexpected ack at cycle %0d", cyc);
            end else begin
                e = q_mem.pop_front();
                chk("a_mem_rdata", mem_rdata, e.data);
                chk("a_mem_ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (b_if_ack) begin
            if (bq_if.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL b_if_ack: unexpected ack at cycle %0d", cyc);
            end else begin
                e = bq_if.pop_front();
                chk("b_if_rdata", b_if_rdata, e.data);
                chk("b_if_ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (b_mem_ack) begin
            if (bq_mem.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL b_mem_ack: unexpected ack at cycle %0d", cyc);
            end else begin
                e = bq_mem.pop_front();
                chk("b_mem_rdata", b_mem_rdata, e.data);
                chk("b_mem_ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int t0;
        if_req = 0; if_addr = 0; flush = 0; mem_rd_req = 0; mem_wr_req = 0;
        mem_addr = 0; mem_wdata = 0;
        b_if_req = 0; b_if_addr = 0; b_flush = 0; b_mem_rd_req = 0; b_mem_wr_req = 0;
        b_mem_addr = 0; b_mem_wdata = 0;

        // Reset state
        repeat (2) @(posedge clock);
        #2;
        chk("rst_if_ack", {31'b0, if_ack}, 32'h0);
        chk("rst_mem_ack", {31'b0, mem_ack}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_ram_en", {31'b0, ram_en}, 32'h0);
        reset = 1;
        step();

        // 1. Fetch 0x40
        step(); t0 = cyc;
        if_req = 1; if_addr = 32'h40;
        q_if.push_back('{32'h2008_0005, t0 + 3});
        sample();
        chk("t1_ram_en_c1", {31'b0, ram_en}, 32'h1);
        chk("t1_ram_we_c1", {31'b0, ram_we}, 32'h0);
        chk("t1_ram_addr_c1", ram_addr, 32'h40);
        chk("t1_stall_c1", {31'b0, stall_if}, 32'h1);
        for (int c = 2; c <= 4; c++) begin
            step(); sample();
            chk("t1_ram_en", {31'b0, ram_en}, 32'h0);
            chk("t1_stall_if", {31'b0, stall_if}, (c == 4) ? 32'h0 : 32'h1);
        end
        step(); if_req = 0;
        step();

        // 2. Collision: MEM read wins, IF issued in the MEM ack cycle
        step(); t0 = cyc;
        if_req = 1; if_addr = 32'h44; mem_rd_req = 1; mem_addr = 32'h100;
        q_mem.push_back('{32'h1111_0100, t0 + 3});
        q_if.push_back('{32'h8C0A_0004, t0 + 6});
        sample();
        chk("t2_ram_addr_c1", ram_addr, 32'h100);
        chk("t2_ram_en_c1", {31'b0, ram_en}, 32'h1);
        for (int c = 2; c <= 7; c++) begin
            step();
            if (c == 5) mem_rd_req = 0;
            sample();
            chk("t2_stall_if", {31'b0, stall_if}, (c == 7) ? 32'h0 : 32'h1);
            if (c == 4) begin
                chk("t2_ram_en_c4", {31'b0, ram_en}, 32'h1);
                chk("t2_ram_addr_c4", ram_addr, 32'h44);
                chk("t2_stall_mem_c4", {31'b0, stall_mem}, 32'h0);
            end
        end
        step(); if_req = 0;
        step();

        // 3. Store: one strobe, ack next cycle, load data reg untouched
        step(); t0 = cyc;
        mem_wr_req = 1; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF;
        q_mem.push_back('{32'h1111_0100, t0 + 1});
        sample();
        chk("t3_ram_we_c1", {31'b0, ram_we}, 32'h1);
        chk("t3_ram_en_c1", {31'b0, ram_en}, 32'h1);
        chk("t3_ram_addr_c1", ram_addr, 32'h200);
        chk("t3_ram_wdata_c1", ram_wdata, 32'hDEAD_BEEF);
        step(); sample();
        chk("t3_ram_en_c2", {31'b0, ram_en}, 32'h0);
        chk("t3_ram_we_c2", {31'b0, ram_we}, 32'h0);
        chk("t3_stall_mem_c2", {31'b0, stall_mem}, 32'h0);
        step(); mem_wr_req = 0;
        // Read the stored word back
        step(); t0 = cyc;
        mem_rd_req = 1; mem_addr = 32'h200;
        q_mem.push_back('{32'hDEAD_BEEF, t0 + 3});
        repeat (3) step();
        step(); mem_rd_req = 0;
        step();

        // 4. Flush squashes the in-flight fetch
        step(); t0 = cyc;
        if_req = 1; if_addr = 32'h48;
        sample();
        chk("t4_ram_addr_c1", ram_addr, 32'h48);
        step(); flush = 1; if_addr = 32'h80;
        sample();
        chk("t4_ram_en_c2", {31'b0, ram_en}, 32'h0);
        step(); flush = 0;
        step();
        q_if.push_back('{32'h0800_0080, t0 + 6});
        sample();
        chk("t4_ram_en_c4", {31'b0, ram_en}, 32'h1);
        chk("t4_ram_addr_c4", ram_addr, 32'h80);
        chk("t4_if_rdata_kept", if_rdata, 32'h8C0A_0004);
        repeat (3) step();
        step(); if_req = 0;
        step();

        // 5. Reset during RD_WAIT, held request reissues once
        step();
        if_req = 1; if_addr = 32'h4C;
        sample();
        chk("t5_ram_en_c1", {31'b0, ram_en}, 32'h1);
        step(); reset = 0;
        sample();
        chk("t5_ram_en_rst", {31'b0, ram_en}, 32'h0);
        chk("t5_if_ack_rst", {31'b0, if_ack}, 32'h0);
        chk("t5_if_rdata_rst", if_rdata, 32'h0);
        step(); sample();
        chk("t5_ram_en_rst2", {31'b0, ram_en}, 32'h0);
        step(); reset = 1; t0 = cyc;
        q_if.push_back('{32'hAC0B_0008, t0 + 3});
        sample();
        chk("t5_ram_en_reissue", {31'b0, ram_en}, 32'h1);
        chk("t5_ram_addr_reissue", ram_addr, 32'h4C);
        repeat (3) step();
        step(); if_req = 0;
        repeat (3) step();

        // 6. MEM_LAT=1 alternating lw/fetch stream, 50 of each
        step(); t0 = cyc;
        for (int c = 0; c <= 203; c++) begin
            if (c > 0) step();
            if (c % 4 == 0 && c < 200) begin
                b_mem_rd_req = 1; b_if_req = 1;
                b_mem_addr = 32'h1000 + 32'(c);
                b_if_addr  = 32'(c);
                bq_mem.push_back('{(32'h1000 + 32'(c)) ^ 32'hA5A5_0000, t0 + c + 2});
                bq_if.push_back('{32'(c) ^ 32'hA5A5_0000, t0 + c + 4});
            end
            if (c == 199) b_mem_rd_req = 0;
            if (c == 201) b_if_req = 0;
            sample();
            if (c < 199) begin
                chk("b_ram_en", {31'b0, b_ram_en}, (c % 2 == 0) ? 32'h1 : 32'h0);
                chk("b_stall_mem", {31'b0, b_stall_mem}, (c % 4 == 2) ? 32'h0 : 32'h1);
                chk("b_stall_if", {31'b0, b_stall_if},
                    (c % 4 == 0 && c > 0) ? 32'h0 : 32'h1);
            end
        end
        repeat (3) step();

        chk("a_if_queue_drained", 32'(q_if.size()), 32'h0);
        chk("a_mem_queue_drained", 32'(q_mem.size()), 32'h0);
        chk("b_if_queue_drained", 32'(bq_if.size()), 32'h0);
        chk("b_mem_queue_drained", 32'(bq_mem.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule
